multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: opcode  in  7  ins[6:0] from instruction register; funct3  in  3  ins[14:12]; funct7b5  in  1  ins[30].
REQ-004 SHALL have ports: zero  in  1  ALU zero flag; mem_ready  in  1  memory completion handshake.
REQ-005 SHALL have ports: pc_we, ir_we, reg_write, mem_read, mem_write, alu_src, mem_to_reg, link  out  1 each; pc_src  out  2 (0 PC+4, 1 branch target, 2 jTarget); alu_op  out  3.
REQ-006 SHALL have ports: state  out  3  current state; trap  out  1  sticky illegal-instruction flag; instret  out  32  retired-instruction count.

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-008 SHALL use alu_op encoding 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; alu_op default 010.
REQ-009 FETCH: mem_read=1; stay while mem_ready=0; on mem_ready=1 pulse ir_we=1, pc_we=1, pc_src=0 that cycle, next DECODE.
REQ-010 DECODE: all strobes 0, one cycle; opcode in {0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 BEQ, 1101111 JAL} -> EXEC; otherwise -> TRAP.
REQ-011 EXEC R/I: alu_src=0 (R) or 1 (I); funct3 000 -> ADD (SUB when R and funct7b5=1), 111 AND, 110 OR, 010 SLT; other funct3 -> TRAP; valid -> WB.
REQ-012 EXEC LW/SW: alu_src=1, alu_op=ADD, next MEM.
REQ-013 EXEC BEQ: alu_src=0, alu_op=SUB; pc_we=zero (combinational same cycle), pc_src=1; retire; next FETCH.
REQ-014 EXEC JAL: reg_write=1, link=1, pc_we=1, pc_src=2; retire; next FETCH.
REQ-015 MEM LW: mem_read=1, wait for mem_ready, then -> WB; MEM SW: mem_write=1, wait for mem_ready, then retire, -> FETCH.
REQ-016 mem_read/mem_write SHALL stay asserted and stable every cycle until mem_ready=1 sampled; never both high.
REQ-017 WB: reg_write=1, mem_to_reg=1 for LW else 0; retire; next FETCH.
REQ-018 Retire SHALL increment instret by 1 on the clock edge leaving the retiring state; wraps FFFFFFFF -> 00000000.
REQ-019 TRAP: trap=1, all strobes 0, instret frozen, remain until rst_n=0.
REQ-020 mem_ready outside FETCH/MEM SHALL be ignored; opcode/funct inputs sampled only in DECODE/EXEC.
REQ-021 Strobes not named for a state SHALL be 0 in that state; pc_src default 0.
REQ-022 CPI: R/I/LW-less = 4 cycles with zero-wait memory (FETCH,DECODE,EXEC,WB); LW 5; SW 4; BEQ/JAL 3; each wait cycle adds 1.

Reset
REQ-023 rst_n=0 SHALL immediately force state=FETCH, trap=0, instret=0, all strobes 0 regardless of clk.
REQ-024 Reset mid-MEM SHALL abort the access: mem_write/mem_read drop asynchronously, no retire, no reg_write.
REQ-025 First rising edge after rst_n deasserts SHALL evaluate FETCH normally.

Verification
REQ-026 ADD R-type (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states 0,1,2,4,0; alu_op=010; reg_write=1 in WB only; instret 0->1.
REQ-027 LW with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles in MEM, then WB with mem_to_reg=1; 8 cycles total; instret +1.
REQ-028 BEQ with zero=1 then zero=0 -> pc_we=1,pc_src=1 in first EXEC; pc_we=0 in second; both retire.
REQ-029 opcode 1111111 -> TRAP after DECODE, trap=1, instret unchanged across 20 further cycles with mem_ready toggling; rst_n pulse returns state=0, trap=0.
REQ-030 instret preloaded via 2^32-1 retirements (or forced) -> next retire reads 00000000; rst_n asserted during SW MEM wait -> mem_write=0 same cycle, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V subset control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing.
// Latency: 3-5 cycles per instruction with zero-wait memory. Each cycle of mem_ready=0 in FETCH/MEM adds one cycle.
// Backpressure: mem_ready stalls FETCH/MEM, and mem_read/mem_write stay asserted until mem_ready is seen.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode/funct3/funct7b5 instruction fields from the IR. Used only in DECODE/EXEC.
//   zero, mem_ready       ALU zero flag, memory completion handshake
//   pc_we .. link, pc_src, alu_op   datapath control strobes
//   state, trap, instret  current state, sticky illegal-instruction flag, retired count
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        link,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        trap,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    // Instruction class latched in DECODE so later states need not look at the IR.
    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BEQ = 3'd4,
        C_JAL = 3'd5
    } iclass_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    state_e      state_q, state_d;
    iclass_e     cls_q, cls_d;
    logic [31:0] instret_q;
    logic        retire;

    logic        pc_we_c, ir_we_c, reg_write_c, mem_read_c, mem_write_c;
    logic        alu_src_c, mem_to_reg_c, link_c;
    logic [1:0]  pc_src_c;
    logic [2:0]  alu_op_c;

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        retire       = 1'b0;
        pc_we_c      = 1'b0;
        ir_we_c      = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        link_c       = 1'b0;
        pc_src_c     = PC_PLUS4;
        alu_op_c     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    OP_R:    cls_d = C_R;
                    OP_I:    cls_d = C_I;
                    OP_LW:   cls_d = C_LW;
                    OP_SW:   cls_d = C_SW;
                    OP_BEQ:  cls_d = C_BEQ;
                    OP_JAL:  cls_d = C_JAL;
                    default: state_d = S_TRAP;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_R, C_I: begin
                        alu_src_c = (cls_q == C_I);
                        state_d   = S_WB;
                        // funct3 is read live from the IR here; it is stable during EXEC.
                        case (funct3)
                            3'b000:  alu_op_c = (cls_q == C_R && funct7b5) ? ALU_SUB : ALU_ADD;
                            3'b111:  alu_op_c = ALU_AND;
                            3'b110:  alu_op_c = ALU_OR;
                            3'b010:  alu_op_c = ALU_SLT;
                            default: state_d  = S_TRAP;
                        endcase
                    end
                    C_LW, C_SW: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op_c = ALU_SUB;
                        // The branch decision uses the same-cycle ALU zero flag.
                        pc_we_c  = zero;
                        pc_src_c = PC_BRANCH;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_JAL: begin
                        reg_write_c = 1'b1;
                        link_c      = 1'b1;
                        pc_we_c     = 1'b1;
                        pc_src_c    = PC_JUMP;
                        retire      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                if (cls_q == C_SW) begin
                    mem_write_c = 1'b1;
                end else begin
                    mem_read_c = 1'b1;
                end
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (cls_q == C_LW);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Strobes are qualified with rst_n. An access in flight drops as soon as reset asserts,
    // without waiting for the state register's FETCH default to take effect on a clock.
    assign pc_we      = rst_n & pc_we_c;
    assign ir_we      = rst_n & ir_we_c;
    assign reg_write  = rst_n & reg_write_c;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign alu_src    = rst_n & alu_src_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign link       = rst_n & link_c;
    assign pc_src     = rst_n ? pc_src_c : PC_PLUS4;
    assign alu_op     = rst_n ? alu_op_c : ALU_ADD;

    assign state   = state_q;
    assign trap    = (state_q == S_TRAP);
    assign instret = instret_q;

endmodule
